mem_access_unit: RTL and testbench

- Load/store sequencer directly upstream of the external memory block (ROM 0x0xxx, RAM 0x1xxx, I/O 0xFxxx).
- Accepts one request at a time from the multicycle controller and drives MemWrite/MemMode/memAddr/memWriteData.
- Loads pass straight through. The external memory writes only whole words, so byte stores (sb) are done as read-modify-write: aligned word read, lane merge, word write.
- Returns a one-cycle response pulse with read data or an error flag.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/mem_access_unit_if.sv | 35 +++
 rtl/byte_lane_merge.sv | 20 ++
 rtl/mem_access_unit.sv | 134 +++++++++++++
 tb/tb_mem_access_unit.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the load/store sequencer: memory mode encodings,
// address region codes and the sequencer state type.
package mem_pkg;

  localparam logic [1:0] MODE_WORD    = 2'b00;
  localparam logic [1:0] MODE_BYTE_S  = 2'b01;
  localparam logic [1:0] MODE_BYTE_U  = 2'b10;
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;

  localparam logic [3:0] REGION_ROM = 4'h0;
  localparam logic [3:0] REGION_RAM = 4'h1;
  localparam logic [3:0] REGION_IO  = 4'hF;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStore,
    StRmwRd,
    StRmwWr,
    StResp
  } mau_state_e;

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus external memory bus for mem_access_unit.
// master: controller + memory side; slave: the sequencer itself.
interface mem_access_unit_if #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 16
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_mode;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [WIDTH-1:0]      req_wdata;
  logic                  resp_valid;
  logic                  resp_err;
  logic [WIDTH-1:0]      resp_rdata;
  logic                  MemWrite;
  logic [1:0]            MemMode;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [WIDTH-1:0]      memWriteData;
  logic [WIDTH-1:0]      memReadData;

  modport master (
    output req_valid, req_write, req_mode, req_addr, req_wdata, memReadData,
    input  req_ready, resp_valid, resp_err, resp_rdata,
    input  MemWrite, MemMode, memAddr, memWriteData
  );

  modport slave (
    input  req_valid, req_write, req_mode, req_addr, req_wdata, memReadData,
    output req_ready, resp_valid, resp_err, resp_rdata,
    output MemWrite, MemMode, memAddr, memWriteData
  );

endinterface

// File: rtl/byte_lane_merge.sv
// Replaces one byte lane of a 32-bit word (lane 0 = bits 7:0, lane 3 = bits 31:24).
module byte_lane_merge (
  input  logic [31:0] word_i,
  input  logic [7:0]  byte_i,
  input  logic [1:0]  lane_i,
  output logic [31:0] merged_o
);

  // Overwrite the selected lane, pass the rest through.
  always_comb begin
    merged_o = word_i;
    case (lane_i)
      2'd0:    merged_o[7:0]   = byte_i;
      2'd1:    merged_o[15:8]  = byte_i;
      2'd2:    merged_o[23:16] = byte_i;
      default: merged_o[31:24] = byte_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of the external memory. Loads pass through,
// word stores write directly, byte stores do aligned read / lane merge / write.
// Optional macro MEM_ACCESS_ALIGN_CHECK_EN: reject misaligned word accesses
// instead of silently aligning them.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input logic               clk,
  input logic               reset,
  mem_access_unit_if.slave  bus_io
);

  mau_state_e            state_q;
  logic                  req_ready_q;
  logic                  resp_valid_q;
  logic                  resp_err_q;
  logic [WIDTH-1:0]      resp_rdata_q;
  logic                  mem_write_q;
  logic [1:0]            mem_mode_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [WIDTH-1:0]      mem_wdata_q;
  logic [7:0]            byte_q;
  logic [1:0]            lane_q;

  logic                  req_err;
  logic [ADDR_WIDTH-1:0] aligned_addr;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [WIDTH-1:0]      merged_word;

  assign aligned_addr = {bus_io.req_addr[ADDR_WIDTH-1:2], 2'b00};

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign req_err   = (bus_io.req_mode == MODE_ILLEGAL) ||
                     ((bus_io.req_mode == MODE_WORD) && (bus_io.req_addr[1:0] != 2'b00));
  assign word_addr = bus_io.req_addr;
`else
  assign req_err   = (bus_io.req_mode == MODE_ILLEGAL);
  assign word_addr = aligned_addr;
`endif

  byte_lane_merge u_merge (
    .word_i   (bus_io.memReadData),
    .byte_i   (byte_q),
    .lane_i   (lane_q),
    .merged_o (merged_word)
  );

  // Sequencer FSM; all handshake and memory outputs are registered here.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_write_q  <= 1'b0;
      mem_mode_q   <= MODE_WORD;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      byte_q       <= '0;
      lane_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus_io.req_valid) begin
            req_ready_q <= 1'b0;
            byte_q      <= bus_io.req_wdata[7:0];
            lane_q      <= bus_io.req_addr[1:0];
            if (req_err) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              state_q      <= StResp;
            end else if (!bus_io.req_write) begin
              mem_mode_q <= bus_io.req_mode;
              mem_addr_q <= (bus_io.req_mode == MODE_WORD) ? word_addr : bus_io.req_addr;
              state_q    <= StLoad;
            end else if (bus_io.req_mode == MODE_WORD) begin
              mem_addr_q  <= word_addr;
              mem_wdata_q <= bus_io.req_wdata;
              mem_write_q <= 1'b1;
              state_q     <= StStore;
            end else begin
              mem_addr_q <= aligned_addr;
              mem_mode_q <= MODE_WORD;
              state_q    <= StRmwRd;
            end
          end
        end
        StLoad: begin
          resp_rdata_q <= bus_io.memReadData;
          mem_mode_q   <= MODE_WORD;
          mem_addr_q   <= '0;
          resp_valid_q <= 1'b1;
          state_q      <= StResp;
        end
        StRmwRd: begin
          // Address stays aligned; write back the word with one lane replaced.
          mem_wdata_q <= merged_word;
          mem_write_q <= 1'b1;
          state_q     <= StRmwWr;
        end
        StStore, StRmwWr: begin
          mem_write_q  <= 1'b0;
          mem_addr_q   <= '0;
          mem_wdata_q  <= '0;
          resp_valid_q <= 1'b1;
          state_q      <= StResp;
        end
        StResp: begin
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
          req_ready_q  <= 1'b1;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.req_ready    = req_ready_q;
  assign bus_io.resp_valid   = resp_valid_q;
  assign bus_io.resp_err     = resp_err_q;
  assign bus_io.resp_rdata   = resp_rdata_q;
  // Gated by reset so an interrupted read-modify-write never lands a write.
  assign bus_io.MemWrite     = mem_write_q & reset;
  assign bus_io.MemMode      = mem_mode_q;
  assign bus_io.memAddr      = mem_addr_q;
  assign bus_io.memWriteData = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word memory.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if #(.WIDTH(32), .ADDR_WIDTH(16)) bus ();

  mem_access_unit #(.WIDTH(32), .ADDR_WIDTH(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  int tests = 0;
  int failed = 0;

  // Memory model: word array, combinational read with byte extraction.
  logic [31:0] ram [16384];
  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [31:0] pl_data = '0;
  int          write_cnt = 0;
  logic [15:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;

  always @(posedge clk) begin
    if (bus.MemWrite) begin
      ram[bus.memAddr[15:2]] <= bus.memWriteData;
      write_cnt  <= write_cnt + 1;
      last_waddr <= bus.memAddr;
      last_wdata <= bus.memWriteData;
    end
    if (pl_en) ram[pl_addr[15:2]] <= pl_data;
  end

  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  always_comb begin
    rd_word = ram[bus.memAddr[15:2]];
    rd_byte = rd_word[8*bus.memAddr[1:0] +: 8];
    case (bus.MemMode)
      MODE_BYTE_S: bus.memReadData = {{24{rd_byte[7]}}, rd_byte};
      MODE_BYTE_U: bus.memReadData = {24'h0, rd_byte};
      default:     bus.memReadData = rd_word;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Issues one request; returns cycles from accept edge to resp_valid plus response fields.
  task automatic do_req(input logic wr, input logic [1:0] mode, input logic [15:0] a,
                        input logic [31:0] wd, output int lat, output logic err,
                        output logic [31:0] rdata, output int writes);
    int w0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_mode = mode;
    bus.req_addr = a; bus.req_wdata = wd;
    w0 = write_cnt;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    err = bus.resp_err;
    rdata = bus.resp_rdata;
    writes = write_cnt - w0;
  endtask

  int          lat;
  logic        err;
  logic [31:0] rdata;
  int          writes;

  initial begin
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_mode = MODE_BYTE_S;
    bus.req_addr = {REGION_RAM, 12'h001}; bus.req_wdata = 32'hAB;

    // Reset held with a byte store pending: never a write.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rst_memwrite", {31'b0, bus.MemWrite}, 32'd0);
    end
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", {31'b0, bus.req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("rst_resp_err", {31'b0, bus.resp_err}, 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_memmode", {30'b0, bus.MemMode}, 32'd0);
    check("rst_memaddr", {16'b0, bus.memAddr}, 32'd0);
    check("rst_memwdata", bus.memWriteData, 32'd0);
    check("rst_writes", write_cnt, 32'd0);

    // Word load.
    preload(16'h1004, 32'hDEADBEEF);
    do_req(1'b0, MODE_WORD, {REGION_RAM, 12'h004}, 32'h0, lat, err, rdata, writes);
    check("wload_lat", lat, 32'd2);
    check("wload_data", rdata, 32'hDEADBEEF);
    check("wload_err", {31'b0, err}, 32'd0);
    check("wload_ready_in_resp", {31'b0, bus.req_ready}, 32'd0);

    // Byte loads.
    preload(16'h1000, 32'h11223384);
    do_req(1'b0, MODE_BYTE_S, 16'h1000, 32'h0, lat, err, rdata, writes);
    check("bload_s_data", rdata, 32'hFFFFFF84);
    do_req(1'b0, MODE_BYTE_U, 16'h1003, 32'h0, lat, err, rdata, writes);
    check("bload_u_data", rdata, 32'h00000011);
    check("bload_u_lat", lat, 32'd2);

    // Byte store via read-modify-write.
    preload(16'h1000, 32'h11223344);
    do_req(1'b1, MODE_BYTE_S, 16'h1001, 32'h000000AB, lat, err, rdata, writes);
    check("bstore_lat", lat, 32'd3);
    check("bstore_writes", writes, 32'd1);
    check("bstore_waddr", {16'b0, last_waddr}, 32'h1000);
    check("bstore_wdata", last_wdata, 32'h1122AB44);
    check("bstore_rdata", rdata, 32'd0);
    check("bstore_err", {31'b0, err}, 32'd0);
    do_req(1'b0, MODE_WORD, 16'h1000, 32'h0, lat, err, rdata, writes);
    check("bstore_readback", rdata, 32'h1122AB44);

    // Byte store to I/O still reads then writes.
    preload({REGION_IO, 12'h010}, 32'hA5A5A5A5);
    do_req(1'b1, MODE_BYTE_U, {REGION_IO, 12'h013}, 32'h0000003C, lat, err, rdata, writes);
    check("io_bstore_lat", lat, 32'd3);
    check("io_bstore_wdata", last_wdata, 32'h3CA5A5A5);

    // ROM word store is passed through to memory.
    do_req(1'b1, MODE_WORD, {REGION_ROM, 12'h008}, 32'h12345678, lat, err, rdata, writes);
    check("rom_store_writes", writes, 32'd1);
    check("rom_store_waddr", {16'b0, last_waddr}, 32'h0008);
    check("rom_store_lat", lat, 32'd2);

    // Illegal mode.
    do_req(1'b1, MODE_ILLEGAL, 16'h1000, 32'hFFFFFFFF, lat, err, rdata, writes);
    check("illegal_lat", lat, 32'd1);
    check("illegal_err", {31'b0, err}, 32'd1);
    check("illegal_writes", writes, 32'd0);
    check("illegal_rdata", rdata, 32'd0);

    // Misaligned word store.
    do_req(1'b1, MODE_WORD, 16'h1002, 32'hCAFEF00D, lat, err, rdata, writes);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    check("misalign_err", {31'b0, err}, 32'd1);
    check("misalign_lat", lat, 32'd1);
    check("misalign_writes", writes, 32'd0);
    do_req(1'b0, MODE_WORD, 16'h1000, 32'h0, lat, err, rdata, writes);
    check("misalign_readback", rdata, 32'h1122AB44);
`else
    check("misalign_err", {31'b0, err}, 32'd0);
    check("misalign_lat", lat, 32'd2);
    check("misalign_waddr", {16'b0, last_waddr}, 32'h1000);
    do_req(1'b0, MODE_WORD, 16'h1000, 32'h0, lat, err, rdata, writes);
    check("misalign_readback", rdata, 32'hCAFEF00D);
`endif

    // Back-to-back: req_valid held high across the response.
    preload(16'h1008, 32'h0BADF00D);
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_mode = MODE_WORD;
    bus.req_addr = 16'h1008;
    @(posedge clk); #1;
    check("b2b_busy_ready", {31'b0, bus.req_ready}, 32'd0);
    @(posedge clk); #1;
    check("b2b_resp1", {31'b0, bus.resp_valid}, 32'd1);
    check("b2b_data1", bus.resp_rdata, 32'h0BADF00D);
    @(posedge clk); #1;
    check("b2b_idle_ready", {31'b0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    check("b2b_accepted", {31'b0, bus.req_ready}, 32'd0);
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check("b2b_resp2", {31'b0, bus.resp_valid}, 32'd1);
    @(posedge clk); #1;
    check("b2b_done", {31'b0, bus.resp_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
